// File: rtl/minibus_sram_slave_if.sv
// minibus link between a master and a memory responder.
// Request side (master -> slave): req_ren, req_wen, req_addr (byte address),
// req_wdata, req_strobe (bit i enables byte i).
// Response side (slave -> master): res_ready (one-cycle pulse), res_rdata, res_error.
interface minibus_sram_slave_if;
    logic        req_ren;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strobe;
    logic        res_ready;
    logic [31:0] res_rdata;
    logic        res_error;

    modport master (
        output req_ren, req_wen, req_addr, req_wdata, req_strobe,
        input  res_ready, res_rdata, res_error
    );

    modport slave (
        input  req_ren, req_wen, req_addr, req_wdata, req_strobe,
        output res_ready, res_rdata, res_error
    );
endinterface

// File: rtl/minibus_sram_slave.sv
// Word-addressed SRAM responder on the minibus.
// Accepts one request at a time, performs byte-strobed writes at acceptance or word
// reads, and answers after WAIT_CYCLES wait states with a one-cycle ready pulse.
// Ports:
//   clk  - system clock, rising edge
//   nrst - asynchronous reset, active HIGH (name follows the bus-wide port name)
//   bus  - minibus slave modport (req_* in, res_* out)
module minibus_sram_slave #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 nrst,
    minibus_sram_slave_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    // Counter holds at most WAIT_CYCLES-1.
    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          rd_q, rd_d;     // accepted op is a valid read
    logic          err_q, err_d;
    logic          ready_q, ready_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          error_q, error_d;

    logic [31:0]   mem [DEPTH];

    logic [32:0]   diff;
    logic          req_in_range;
    logic          req_err;
    logic [AW-1:0] req_idx;
    logic          accept;

    // 33-bit subtraction so addresses below BASE_ADDR borrow instead of wrapping.
    always_comb begin
        diff         = {1'b0, bus.req_addr} - {1'b0, BASE_ADDR};
        req_in_range = !diff[32] && ({1'b0, diff[31:0]} < SPAN);
        req_err      = (bus.req_ren & bus.req_wen) | (bus.req_addr[1:0] != 2'b00) |
                       !req_in_range;
        req_idx      = diff[AW+1:2];
        accept       = (state_q == ST_IDLE) && (bus.req_ren | bus.req_wen);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rd_d    = rd_q;
        err_d   = err_q;
        ready_d = 1'b0;
        rdata_d = '0;
        error_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    idx_d = req_idx;
                    rd_d  = bus.req_ren & !req_err;
                    err_d = req_err;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CW'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_RESP;
                else             cnt_d   = cnt_q - CW'(1);
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Response registers load on the edge entering RESP; RESP never repeats.
        if (state_d == ST_RESP && state_q != ST_RESP) begin
            ready_d = 1'b1;
            error_d = err_d;
            rdata_d = rd_d ? mem[idx_d] : '0;
        end
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // Array is not reset; writes commit at the acceptance edge.
    always_ff @(posedge clk) begin
        if (!nrst && accept && bus.req_wen && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_strobe[i]) mem[req_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
            end
        end
    end

    assign bus.res_ready = ready_q;
    assign bus.res_rdata = rdata_q;
    assign bus.res_error = error_q;
endmodule

// File: tb/tb_minibus_sram_slave.sv
module tb_minibus_sram_slave;
    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic clk  = 1'b0;
    logic nrst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    minibus_sram_slave_if b0 ();
    minibus_sram_slave_if b1 ();
    minibus_sram_slave_if b2 ();

    minibus_sram_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) u_w0 (
        .clk(clk), .nrst(nrst), .bus(b0));
    minibus_sram_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(1), .BASE_ADDR(BASE)) u_w1 (
        .clk(clk), .nrst(nrst), .bus(b1));
    minibus_sram_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(3), .BASE_ADDR(BASE)) u_w3 (
        .clk(clk), .nrst(nrst), .bus(b2));

    int n_checks = 0;
    int n_errors = 0;
    int last_ready_cyc = 0;
    logic [31:0] ref_mem [3][DEPTH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int wait_of(input int d);
        case (d)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    task automatic drive(input int d, input logic ren, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strobe);
        case (d)
            0: begin
                b0.req_ren = ren; b0.req_wen = wen; b0.req_addr = addr;
                b0.req_wdata = wdata; b0.req_strobe = strobe;
            end
            1: begin
                b1.req_ren = ren; b1.req_wen = wen; b1.req_addr = addr;
                b1.req_wdata = wdata; b1.req_strobe = strobe;
            end
            default: begin
                b2.req_ren = ren; b2.req_wen = wen; b2.req_addr = addr;
                b2.req_wdata = wdata; b2.req_strobe = strobe;
            end
        endcase
    endtask

    task automatic sample(input int d, output logic rdy, output logic [31:0] rd, output logic er);
        case (d)
            0:       begin rdy = b0.res_ready; rd = b0.res_rdata; er = b0.res_error; end
            1:       begin rdy = b1.res_ready; rd = b1.res_rdata; er = b1.res_error; end
            default: begin rdy = b2.res_ready; rd = b2.res_rdata; er = b2.res_error; end
        endcase
    endtask

    // One transaction: predict from the memory model, issue, wait for ready, check.
    task automatic do_txn(input int d, input logic ren, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strobe);
        logic [32:0] a, lo, hi;
        logic        exp_err, rdy, er, seen;
        logic [31:0] exp_rd, rd, off;
        int          idx, lat;
        a       = {1'b0, addr};
        lo      = {1'b0, BASE};
        hi      = lo + 33'(DEPTH * 4);
        exp_err = (ren && wen) || (addr[1:0] != 2'b00) || (a < lo) || (a >= hi);
        off     = addr - BASE;
        idx     = int'(off >> 2);
        exp_rd  = '0;
        if (!exp_err && wen)
            for (int i = 0; i < 4; i++)
                if (strobe[i]) ref_mem[d][idx][8*i +: 8] = wdata[8*i +: 8];
        if (!exp_err && ren) exp_rd = ref_mem[d][idx];

        drive(d, ren, wen, addr, wdata, strobe);
        seen = 1'b0;
        lat  = 0;
        rd   = '0;
        er   = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(posedge clk); #1;
            // After acceptance the request may change; the captured copy must be used.
            if (k == 1) drive(d, 1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom));
            sample(d, rdy, rd, er);
            if (rdy) begin
                seen = 1'b1;
                lat  = k;
                last_ready_cyc = cyc;
            end
        end
        check_eq($sformatf("d%0d latency addr=%h", d, addr), lat, 1 + wait_of(d));
        check_eq($sformatf("d%0d error addr=%h", d, addr), {31'd0, er}, {31'd0, exp_err});
        check_eq($sformatf("d%0d rdata addr=%h", d, addr), rd, exp_rd);
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b0, '0, '0, '0);
        sample(d, rdy, rd, er);
        check_eq($sformatf("d%0d ready width", d), {31'd0, rdy}, 32'd0);
        check_eq($sformatf("d%0d rdata idle", d), rd, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        rdy, er;
        logic [31:0] rd;
        int          prev;

        // Reset with a pending read on every port; outputs must stay quiet.
        for (int d = 0; d < 3; d++) drive(d, 1'b1, 1'b0, BASE, '0, '0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                sample(d, rdy, rd, er);
                check_eq($sformatf("rst ready d%0d", d), {31'd0, rdy}, 32'd0);
                check_eq($sformatf("rst error d%0d", d), {31'd0, er}, 32'd0);
                check_eq($sformatf("rst rdata d%0d", d), rd, 32'd0);
            end
        end
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, '0, '0, '0);
        nrst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                sample(d, rdy, rd, er);
                check_eq($sformatf("post-rst ready d%0d", d), {31'd0, rdy}, 32'd0);
            end
        end

        // Fill every word so later reads have defined contents.
        for (int d = 0; d < 3; d++)
            for (int w = 0; w < DEPTH; w++)
                do_txn(d, 1'b0, 1'b1, BASE + 32'(4 * w), $urandom, 4'hF);

        // Directed write/read, strobes and error classes on the one-wait-state port.
        do_txn(1, 1'b0, 1'b1, BASE + 32'd8, 32'hDEAD_BEEF, 4'hF);
        do_txn(1, 1'b1, 1'b0, BASE + 32'd8, '0, '0);
        do_txn(1, 1'b0, 1'b1, BASE, 32'h1122_3344, 4'hF);
        do_txn(1, 1'b0, 1'b1, BASE, 32'hAABB_CCDD, 4'b0101);
        do_txn(1, 1'b1, 1'b0, BASE, '0, '0);
        do_txn(1, 1'b1, 1'b0, BASE + 32'd2, '0, '0);
        do_txn(1, 1'b1, 1'b0, BASE + 32'(DEPTH * 4), '0, '0);
        do_txn(1, 1'b1, 1'b1, BASE, 32'hFFFF_FFFF, 4'hF);
        do_txn(1, 1'b0, 1'b1, BASE + 32'd2, 32'h0BAD_0BAD, 4'hF);
        do_txn(1, 1'b0, 1'b1, BASE - 32'd4, 32'h0BAD_0BAD, 4'hF);
        do_txn(1, 1'b0, 1'b1, BASE + 32'd8, 32'h0BAD_0BAD, 4'h0);
        do_txn(1, 1'b1, 1'b0, BASE, '0, '0);
        do_txn(1, 1'b1, 1'b0, BASE + 32'd8, '0, '0);

        // Zero wait states: back-to-back reads answer on alternate cycles.
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            do_txn(0, 1'b1, 1'b0, BASE + 32'(4 * $urandom_range(0, DEPTH - 1)), '0, '0);
            if (i > 0) check_eq("b2b spacing", 32'(last_ready_cyc - prev), 32'd2);
            prev = last_ready_cyc;
        end

        // Three wait states: a few reads and writes.
        do_txn(2, 1'b0, 1'b1, BASE + 32'd4, 32'h0123_4567, 4'hF);
        do_txn(2, 1'b1, 1'b0, BASE + 32'd4, '0, '0);

        // Reset two cycles into the wait of a write: no ready, write still committed.
        drive(2, 1'b0, 1'b1, BASE + 32'd12, 32'h5A5A_5A5A, 4'hF);
        ref_mem[2][3] = 32'h5A5A_5A5A;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            sample(2, rdy, rd, er);
            check_eq("mid-wait ready before rst", {31'd0, rdy}, 32'd0);
        end
        nrst = 1'b1;
        drive(2, 1'b0, 1'b0, '0, '0, '0);
        for (int c = 0; c < 6; c++) begin
            if (c == 2) nrst = 1'b0;
            @(posedge clk); #1;
            sample(2, rdy, rd, er);
            check_eq("mid-wait ready after rst", {31'd0, rdy}, 32'd0);
        end
        do_txn(2, 1'b1, 1'b0, BASE + 32'd12, '0, '0);

        // Randomized mix on every port.
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 30; n++) begin
                int          op, ak;
                logic        ren, wen;
                logic [31:0] addr;
                op   = $urandom_range(0, 8);
                ren  = (op <= 3) || (op == 8);
                wen  = (op >= 4);
                ak   = $urandom_range(0, 9);
                addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
                if (ak == 7) addr = addr + 32'($urandom_range(1, 3));
                if (ak == 8) addr = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 3));
                if (ak == 9) addr = BASE - 32'(4 * $urandom_range(1, 4));
                do_txn(d, ren, wen, addr, $urandom, 4'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/minibus_sram_slave.md
# minibus_sram_slave

Word-addressed SRAM responder on the minibus: the decoder-side end of the `minibus_master_if` link. It accepts one request at a time from `req` and executes byte-strobed writes or word reads on an internal array. After a programmable number of wait states it answers on `res` with a single-cycle `ready` pulse carrying read data or an error flag. It is the default memory target behind the minibus decoder, and the reference responder for master-side verification.

## Interface

- `DEPTH`, 1024: number of 32-bit words; a power of two, minimum 2.
- `WAIT_CYCLES`, 1: wait states between acceptance and response; 0 is legal.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to DEPTH*4.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `nrst`  input  1  asynchronous, active-high reset: 1 = reset asserted. The name follows the bus-wide port name.
- `req`  input  minibus_req_pack  fields used:
  - `ren` (1)
  - `wen` (1)
  - `addr` (32, byte address)
  - `wdata` (32)
  - `strobe` (4, byte enables, bit i = byte i)
- `res`  output  minibus_res_pack  fields driven:
  - `ready` (1)
  - `rdata` (32)
  - `error` (1)

## Operation

- Protocol: the master holds `req` stable from issue until it samples `res.ready`=1. In the following cycle it may drop the request or present a new one. Each request produces exactly one `ready` pulse.
- The FSM has three states: IDLE, WAIT and RESP. Reset state is IDLE.
- IDLE:
  - If `ren|wen`=1, capture `addr`, `wdata`, `strobe` and the op, and classify the request.
  - Go to WAIT if WAIT_CYCLES>0, else go to RESP.
  - If no request is present, stay in IDLE.
- WAIT: a counter loads WAIT_CYCLES-1 on entry and decrements each cycle. At 0, go to RESP.
- RESP: drive `ready`=1 for exactly one cycle, then return to IDLE unconditionally.
- Error classes, checked in IDLE:
  - `ren&wen` both set.
  - `addr[1:0]`!=0.
  - `addr` outside [BASE_ADDR, BASE_ADDR+DEPTH*4).
- Error response:
  - `error`=1 and `rdata`=0.
  - The array is not modified.
  - Wait-state timing is identical to a normal request.
- Write:
  - Performed at the acceptance edge (end of the IDLE cycle), only for valid requests.
  - Bytes are written only where `strobe[i]`=1.
  - `strobe`=0 is a legal no-op write with `error`=0.
  - Write response has `rdata`=0.
- Read:
  - Word index = (`addr`-BASE_ADDR)>>2.
  - Data is registered on the edge entering RESP.
  - `rdata` is valid only while `ready`=1; it is 0 in every other cycle.
- Outputs (`ready`, `rdata`, `error`) are driven from registers only; no combinational path from `req` to `res`.
- Array contents are not reset.

## Timing

- Reset values: `ready`=0, `rdata`=0, `error`=0, state IDLE, wait counter 0.
- Reset asserted mid-transaction:
  - The transaction is abandoned immediately and no `ready` is issued.
  - A write already committed at acceptance stays in the array.
- Latency: a request first seen in IDLE at cycle T gets `ready` at cycle T+1+WAIT_CYCLES.
  - WAIT_CYCLES=0 gives `ready` at T+1.
  - WAIT_CYCLES=1 gives `ready` at T+2.
- Throughput: back-to-back requests are accepted in the cycle after `ready`. With WAIT_CYCLES=0 that is one transaction every 2 cycles.
- `req` changes while in WAIT/RESP are ignored, since the captured copy is used.
- Read-after-write to the same word, back-to-back, returns the new data: the write commits before the read's acceptance cycle.
- `addr` arithmetic is unsigned 32-bit. `addr` below BASE_ADDR is out of range and must not wrap into the array.

## Test plan

- Reset and idle check: assert `nrst`=1 for 3 cycles with `req.ren`=1, then release with `req` idle. Required: `ready`, `error` and `rdata` stay 0 throughout.
- Write then read, WAIT_CYCLES=1:
  - Write 32'hDEAD_BEEF to BASE_ADDR+8 with `strobe`=4'hF. Required: `ready` at T+2 with `error`=0.
  - Next cycle, read BASE_ADDR+8. Required: `ready` two cycles after acceptance with `rdata`=32'hDEAD_BEEF.
- Byte strobes: word 0 holds 32'h1122_3344. Write 32'hAABB_CCDD with `strobe`=4'b0101. Required: a readback of 32'h11BB_33DD.
- Errors, each with `error`=1, `rdata`=0 at normal latency, and the target word unchanged on readback:
  - read at BASE_ADDR+2 (misaligned)
  - read at BASE_ADDR+DEPTH*4 (out of range)
  - `ren`=`wen`=1 at BASE_ADDR
- Latency sweep:
  - WAIT_CYCLES=0: 8 back-to-back reads show `ready` on alternate cycles.
  - WAIT_CYCLES=3: `ready` falls 4 cycles after acceptance.
  - In both cases `ready` is exactly one cycle wide.
- Reset mid-WAIT, WAIT_CYCLES=3: assert reset 2 cycles after acceptance of a write of 32'h5A5A_5A5A. Required: no `ready` is ever issued, and a subsequent read returns 32'h5A5A_5A5A.
